// File: rtl/design_select_loader_if.sv
// Design-select loader bus: the three async configuration pins plus the committed
// selection outputs that feed the shared design multiplexer.
interface design_select_loader_if;
  logic       cfg_csn;
  logic       cfg_sck;
  logic       cfg_sdi;
  logic [5:0] des_sel;
  logic       hold_if_not_sel;
  logic       sync_inputs;
  logic       sel_reset;
  logic       cfg_busy;
  logic       cfg_err;

  modport master (
    output cfg_csn, cfg_sck, cfg_sdi,
    input  des_sel, hold_if_not_sel, sync_inputs, sel_reset, cfg_busy, cfg_err
  );

  modport slave (
    input  cfg_csn, cfg_sck, cfg_sdi,
    output des_sel, hold_if_not_sel, sync_inputs, sel_reset, cfg_busy, cfg_err
  );
endinterface

// File: rtl/design_select_loader.sv
// Receives a 9-bit serial select frame on async pins, checks length and even parity,
// commits the selection atomically and then pulses a reset toward the chosen design.
module design_select_loader #(
  parameter int         SYNC_STAGES  = 2,
  parameter int         RESET_CYCLES = 16,
  parameter logic [5:0] DEFAULT_SEL  = 6'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  design_select_loader_if.slave cfg
);
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMMIT   = 2'd2,
    RST_HOLD = 2'd3
  } state_t;

  function automatic logic parity_ok(input logic [8:0] frame);
    return ~(^frame);
  endfunction

  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic                   csn_last_r;
  logic                   sck_last_r;
  logic                   csn_fall_s;
  logic                   csn_rise_s;
  logic                   sck_rise_s;
  logic                   sdi_s;

  state_t                 state_r;
  logic [8:0]             shift_r;
  logic [3:0]             bit_cnt_r;
  logic [CNT_W-1:0]       rst_cnt_r;
  logic [5:0]             des_sel_r;
  logic                   hold_r;
  logic                   sync_in_r;
  logic                   sel_reset_r;
  logic                   busy_r;
  logic                   err_r;

  // Pin synchronisers; csn resets high so a quiet pin never looks like a frame start
  always_ff @(posedge clock) begin
    if (reset) begin
      csn_sync_r <= {SYNC_STAGES{1'b1}};
      sck_sync_r <= {SYNC_STAGES{1'b0}};
      sdi_sync_r <= {SYNC_STAGES{1'b0}};
      csn_last_r <= 1'b1;
      sck_last_r <= 1'b0;
    end else begin
      csn_sync_r <= {csn_sync_r[SYNC_STAGES-2:0], cfg.cfg_csn};
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], cfg.cfg_sck};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], cfg.cfg_sdi};
      csn_last_r <= csn_sync_r[SYNC_STAGES-1];
      sck_last_r <= sck_sync_r[SYNC_STAGES-1];
    end
  end

  assign csn_fall_s = csn_last_r & ~csn_sync_r[SYNC_STAGES-1];
  assign csn_rise_s = ~csn_last_r & csn_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = ~sck_last_r & sck_sync_r[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_r[SYNC_STAGES-1];

  // Frame FSM; csn edges outside IDLE/SHIFT are ignored, which drops frames sent while busy
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_r     <= 9'd0;
      bit_cnt_r   <= 4'd0;
      rst_cnt_r   <= '0;
      des_sel_r   <= DEFAULT_SEL;
      hold_r      <= 1'b1;
      sync_in_r   <= 1'b0;
      sel_reset_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (csn_fall_s) begin
            shift_r   <= 9'd0;
            bit_cnt_r <= 4'd0;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          if (csn_rise_s) begin
            if ((bit_cnt_r == 4'd9) && parity_ok(shift_r)) begin
              busy_r  <= 1'b1;
              state_r <= COMMIT;
            end else begin
              err_r   <= 1'b1;
              state_r <= IDLE;
            end
          end else if (sck_rise_s) begin
            shift_r <= {shift_r[7:0], sdi_s};
            if (bit_cnt_r != 4'd15) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        COMMIT: begin
          des_sel_r   <= shift_r[8:3];
          hold_r      <= shift_r[2];
          sync_in_r   <= shift_r[1];
          err_r       <= 1'b0;
          sel_reset_r <= 1'b1;
          rst_cnt_r   <= CNT_W'(RESET_CYCLES);
          state_r     <= RST_HOLD;
        end
        RST_HOLD: begin
          // sel_reset was raised on the commit edge, so the last counted cycle drops it
          if (rst_cnt_r <= CNT_W'(1)) begin
            rst_cnt_r   <= '0;
            sel_reset_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rst_cnt_r <= rst_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          sel_reset_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cfg.des_sel         = des_sel_r;
  assign cfg.hold_if_not_sel = hold_r;
  assign cfg.sync_inputs     = sync_in_r;
  assign cfg.sel_reset       = sel_reset_r;
  assign cfg.cfg_busy        = busy_r;
  assign cfg.cfg_err         = err_r;
endmodule

// File: tb/tb_design_select_loader.sv
// Scoreboard bench: valid frames push their expected selection, and a monitor pops and
// compares it on every rising edge of sel_reset (the commit event).
module tb_design_select_loader;
  logic clock;
  logic reset;
  design_select_loader_if bus();

  design_select_loader #(
    .SYNC_STAGES (2),
    .RESET_CYCLES(16),
    .DEFAULT_SEL (6'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg  (bus)
  );

  int         checks;
  int         failures;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;
  logic       sr_prev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Commit monitor: every sel_reset rise must match the oldest pending frame
  always @(negedge clock) begin
    if (bus.sel_reset === 1'b1 && sr_prev !== 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_commit: got des_sel=%0d with no valid frame pending", bus.des_sel);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs} !== mon_exp) begin
          failures++;
          $display("FAIL commit_fields: got %h expected %h",
                   {bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs}, mon_exp);
        end
      end
    end
    sr_prev = bus.sel_reset;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.cfg_sdi = bits[i];
      bus.cfg_sck = 1'b0;
      cyc(4);
      bus.cfg_sck = 1'b1;
      cyc(4);
    end
    bus.cfg_sck = 1'b0;
    cyc(4);
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    bus.cfg_csn = 1'b0;
    cyc(4);
    shift_bits(bits, n);
    bus.cfg_csn = 1'b1;
    cyc(30);
  endtask

  task automatic check_sel(input string name, input logic [5:0] sel, input logic hold,
                           input logic sync, input logic err);
    checks++;
    if ({bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs, bus.cfg_err} !== {sel, hold, sync, err}) begin
      failures++;
      $display("FAIL %s: got sel=%0d hold=%b sync=%b err=%b expected sel=%0d hold=%b sync=%b err=%b",
               name, bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs, bus.cfg_err,
               sel, hold, sync, err);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected commits never happened", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if ({bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs, bus.sel_reset, bus.cfg_busy, bus.cfg_err}
          !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle: got %0d bad cycles expected 0", bad);
    end
    check_sel("reset_values", 6'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_valid_frame();
    int first_i;
    int busy_cnt;
    int sr_cnt;
    first_i  = 0;
    busy_cnt = 0;
    sr_cnt   = 0;
    sb_q.push_back({6'd13, 1'b0, 1'b1});
    bus.cfg_csn = 1'b0;
    cyc(4);
    shift_bits(16'b001101010, 9);
    bus.cfg_csn = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      if (first_i == 0 && bus.des_sel === 6'd13) first_i = i;
      if (bus.cfg_busy === 1'b1) busy_cnt++;
      if (bus.sel_reset === 1'b1) sr_cnt++;
    end
    checks++;
    if (first_i != 4) begin
      failures++;
      $display("FAIL commit_latency: got %0d edges expected 4", first_i);
    end
    checks++;
    if (sr_cnt != 16) begin
      failures++;
      $display("FAIL sel_reset_width: got %0d cycles expected 16", sr_cnt);
    end
    checks++;
    if (busy_cnt != 17) begin
      failures++;
      $display("FAIL busy_width: got %0d cycles expected 17", busy_cnt);
    end
    check_sel("valid_frame", 6'd13, 1'b0, 1'b1, 1'b0);
    check_queue_empty("valid_frame_commit");
  endtask

  task automatic test_parity_error();
    send_frame(16'b000110111, 9);
    check_sel("parity_error", 6'd13, 1'b0, 1'b1, 1'b1);
    check_queue_empty("parity_error_queue");
  endtask

  task automatic test_length_error();
    send_frame(16'b00011011, 8);
    check_sel("short_frame", 6'd13, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    send_frame(16'b000000110110, 12);
    check_sel("long_frame", 6'd13, 1'b0, 1'b1, 1'b1);
    sb_q.push_back({6'd6, 1'b1, 1'b1});
    send_frame(16'b000110110, 9);
    check_sel("recover_frame", 6'd6, 1'b1, 1'b1, 1'b0);
    check_queue_empty("length_error_queue");
  endtask

  task automatic test_busy_drop();
    sb_q.push_back({6'd42, 1'b1, 1'b0});
    bus.cfg_csn = 1'b0;
    cyc(4);
    shift_bits(16'b101010100, 9);
    bus.cfg_csn = 1'b1;
    cyc(9);
    checks++;
    if (bus.cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_during_hold: got %b expected 1", bus.cfg_busy);
    end
    bus.cfg_csn = 1'b0;
    cyc(4);
    shift_bits(16'b000001001, 9);
    bus.cfg_csn = 1'b1;
    cyc(30);
    check_sel("busy_drop", 6'd42, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_released: got %b expected 0", bus.cfg_busy);
    end
    check_queue_empty("busy_drop_queue");
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] frame;
    frame = 9'b011111001;
    bus.cfg_csn = 1'b0;
    cyc(4);
    for (int i = 8; i >= 5; i--) begin
      bus.cfg_sdi = frame[i];
      bus.cfg_sck = 1'b0;
      cyc(4);
      bus.cfg_sck = 1'b1;
      cyc(4);
    end
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check_sel("mid_frame_reset", 6'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.sel_reset, bus.cfg_busy} !== 2'b00) begin
      failures++;
      $display("FAIL mid_frame_reset_ctl: got %b expected 00", {bus.sel_reset, bus.cfg_busy});
    end
    bus.cfg_sck = 1'b0;
    cyc(4);
    shift_bits({11'd0, frame[4:0]}, 5);
    bus.cfg_csn = 1'b1;
    cyc(30);
    checks++;
    if ({bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs, bus.sel_reset} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL no_commit_after_reset: got sel=%0d hold=%b sync=%b rst=%b expected sel=0 hold=1 sync=0 rst=0",
               bus.des_sel, bus.hold_if_not_sel, bus.sync_inputs, bus.sel_reset);
    end
    check_queue_empty("mid_frame_queue");
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sr_prev     = 1'b0;
    reset       = 1'b1;
    bus.cfg_csn = 1'b1;
    bus.cfg_sck = 1'b0;
    bus.cfg_sdi = 1'b0;
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_length_error();
    test_busy_drop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/design_select_loader.md
Name: design_select_loader

Overview:
- Upstream configuration stage that drives the design-select controls of the shared design multiplexer: `des_sel`, `hold_if_not_sel` and `sync_inputs`.
- Receives a 9-bit serial frame on three asynchronous chip pins: `cfg_csn` (frame enable), `cfg_sck` (bit clock) and `cfg_sdi` (data).
- Checks frame length and parity, then atomically commits the new selection.
- After each commit, pulses a reset toward the newly selected design so it starts from a known state.

Parameters:
- SYNC_STAGES, 2, flop stages on each async pin (minimum 2).
- RESET_CYCLES, 16, cycles `sel_reset` stays high after a commit (minimum 1).
- DEFAULT_SEL, 6'd0, value of `des_sel` after reset.

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- cfg_csn  in  1  async pin; frame active while low.
- cfg_sck  in  1  async pin; data sampled on its rising edge.
- cfg_sdi  in  1  async pin; serial data, MSB first.
- des_sel  out  6  committed design index.
- hold_if_not_sel  out  1  committed hold flag.
- sync_inputs  out  1  committed input-synchroniser enable.
- sel_reset  out  1  reset pulse for the newly selected design.
- cfg_busy  out  1  high in the COMMIT and RST_HOLD states.
- cfg_err  out  1  sticky flag: last frame was rejected.

Behaviour:
- Reset values:
  - `des_sel` = DEFAULT_SEL, `hold_if_not_sel` = 1, `sync_inputs` = 0.
  - `sel_reset` = 0, `cfg_busy` = 0, `cfg_err` = 0, state IDLE.
  - Synchroniser chains reset to `csn` = 1, `sck` = 0, `sdi` = 0; no false frame start after reset.
  - Reset mid-frame or mid-RST_HOLD aborts immediately to these values.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops.
  - Edge detection compares the last stage against one further registered copy.
  - Pins must hold each level for at least 2 clock cycles; faster toggling is unsupported.
- Frame format (9 bits, MSB first):
  - bits [8:3] = `des_sel`, bit [2] = `hold_if_not_sel`, bit [1] = `sync_inputs`, bit [0] = parity.
  - Parity is even: the XOR of all 9 bits must be 0.
- State IDLE:
  - On a synced falling edge of `csn`: clear the 9-bit shift register and the 4-bit bit count, then go to SHIFT.
- State SHIFT:
  - On a synced rising edge of `sck`: shift `sdi` into the LSB and increment the count. The count saturates at 15.
  - On a synced rising edge of `csn`: if count == 9 and parity is good, go to COMMIT. Otherwise set `cfg_err` = 1 and go to IDLE; outputs are unchanged.
  - If `csn` rises and `sck` rises in the same cycle, `csn` wins and that `sck` edge is ignored.
- State COMMIT (one cycle):
  - Register the frame fields into the outputs, clear `cfg_err`, load the reset counter with RESET_CYCLES, then go to RST_HOLD.
- State RST_HOLD:
  - `sel_reset` = 1 for exactly RESET_CYCLES cycles, starting in the first cycle the new `des_sel` is visible; the counter decrements each cycle.
  - When the counter reaches 0, `sel_reset` drops and the state returns to IDLE.
- Busy handling:
  - `cfg_busy` = 1 in COMMIT and RST_HOLD.
  - `csn` edges seen while busy are ignored. A frame started during busy is lost, and `cfg_err` is not set. Software must wait for `cfg_busy` to fall before starting a new frame.
- Latency:
  - The new `des_sel` is visible at the output SYNC_STAGES+2 clock edges after the first edge that samples `cfg_csn` high on the pin.
- Atomicity:
  - `des_sel`, `hold_if_not_sel` and `sync_inputs` always change on the same edge; no partial updates.
- Re-selecting the current value is a valid frame: it commits and still issues the `sel_reset` pulse.

Test Plan:
- Reset check: assert `reset` for 3 cycles, then hold the pins idle for 50 cycles -> `des_sel` = 0, `hold_if_not_sel` = 1, `sync_inputs` = 0, `sel_reset` = 0, `cfg_err` = 0 throughout.
- Valid frame: send 9'b001101_0_1_0, holding each `sck` level 4 cycles -> `des_sel` = 13, `hold_if_not_sel` = 0, `sync_inputs` = 1 exactly 4 edges after `csn` is sampled high; `sel_reset` high for exactly 16 cycles; `cfg_busy` high for 17 cycles.
- Parity error: send 9'b000110_1_1_1 -> `cfg_err` = 1; `des_sel` stays at its prior value; `sel_reset` never asserts.
- Length error: send 8 bits and then, separately, 12 bits, each forming a valid value -> both frames are rejected with `cfg_err` = 1. A following valid frame 9'b000110_1_1_0 commits `des_sel` = 6 and clears `cfg_err`.
- Busy drop: start a second frame 5 cycles into RST_HOLD -> that frame is ignored, `des_sel` is unchanged and `cfg_err` = 0.
- Reset mid-frame: assert `reset` after 4 bits have shifted in -> all outputs return to reset values; the remaining bits and the `csn` rise produce no commit.
